fb_loader: RTL

FB_LOADER -- requirements
Module: fb_loader

---
 rtl/fb_pkg.sv | 45 ++++
 rtl/fb_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer loader. These cover the frame
// geometry, the default frame size in 32-bit words, the bus widths, and the
// loader FSM state encoding.
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int unsigned FB_WIDTH        = 800;
   localparam int unsigned FB_HEIGHT       = 600;
   localparam int unsigned PIXEL_W         = 8;    // RGB332
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned ADDR_W          = 20;
   localparam int unsigned PIXELS_PER_WORD = WORD_W / PIXEL_W;

   // 800*600/4 = 120000 words per frame
   localparam int unsigned FRAME_WORDS_DEFAULT = (FB_WIDTH * FB_HEIGHT) / PIXELS_PER_WORD;

   // Encoding matches the legacy 3-bit state values
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_REQ     = 3'd2,
      ST_SETUP   = 3'd3,
      ST_PULSE   = 3'd4,
      ST_HOLD    = 3'd5,
      ST_DONE    = 3'd6
   } fb_state_t;

   // A frame load is in progress in every state except IDLE and DONE
   function automatic logic state_is_busy(input fb_state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE));
   endfunction

   // The bus is held by the loader from REQ through HOLD
   function automatic logic state_owns_bus(input fb_state_t s);
      return (s == ST_REQ) || (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_HOLD);
   endfunction

   // SRAM is selected and driven during the three write-cycle states
   function automatic logic state_drives_sram(input fb_state_t s);
      return (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/fb_loader.sv
// -----------------------------------------------------------------------------
// fb_loader
// Packs RGB332 pixel bytes from the UART receiver into 32-bit words. Each word
// is written to base SRAM through the bus arbiter with a three-cycle
// SETUP / PULSE / HOLD write strobe. One frame of FRAME_WORDS words is written
// per start pulse, starting at BASE_ADDR.
//
// Ports
//   clk_10M          in   1  clock, rising edge
//   reset_of_clk10M  in   1  asynchronous reset, active-high
//   start            in   1  pulse: begin loading one frame (ignored while busy)
//   in_data          in   8  pixel byte
//   in_valid         in   1  in_data valid
//   in_ready         out  1  byte accepted when in_valid & in_ready
//   ram_req          out  1  bus request to arbiter
//   ram_gnt          in   1  bus grant (sampled only while requesting)
//   ram_addr         out 20  SRAM word address
//   ram_wdata        out 32  SRAM write data (byte k of the word in [8k+7:8k])
//   ram_data_oe      out  1  tristate enable for ram_wdata
//   ram_ce_n         out  1  chip enable, active-low
//   ram_oe_n         out  1  read enable, active-low (never asserted)
//   ram_we_n         out  1  write enable, active-low
//   ram_be_n         out  4  byte enables, active-low (all bytes)
//   busy             out  1  frame load in progress
//   done             out  1  frame complete, held until next start
//   overrun          out  1  sticky: byte offered while not ready during a load
//   words_written    out 20  words committed in the current frame
// -----------------------------------------------------------------------------
module fb_loader
   import fb_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
   parameter logic [19:0] BASE_ADDR   = 20'h00000
) (
   input  logic        clk_10M,
   input  logic        reset_of_clk10M,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        ram_req,
   input  logic        ram_gnt,
   output logic [19:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_data_oe,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic [3:0]  ram_be_n,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   output logic [19:0] words_written
);

   localparam logic [19:0] LAST_COUNT = 20'(FRAME_WORDS);

   fb_state_t   state;
   fb_state_t   state_nxt;
   logic [1:0]  lane;
   logic        accept;
   logic        start_ok;
   logic [19:0] words_inc;
   logic        last_word;

   // Writes are whole-word and read strobe is never used
   assign ram_oe_n = 1'b1;
   assign ram_be_n = 4'b0000;

   // in_ready is registered and high exactly in COLLECT, so it doubles as the
   // "state is COLLECT" qualifier for byte acceptance
   assign accept    = in_valid & in_ready;
   assign start_ok  = start & ~state_is_busy(state);
   assign words_inc = words_written + 20'd1;
   assign last_word = (words_inc == LAST_COUNT);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE,
         ST_DONE:    if (start)                     state_nxt = ST_COLLECT;
         ST_COLLECT: if (accept && (lane == 2'd3))  state_nxt = ST_REQ;
         ST_REQ:     if (ram_gnt)                   state_nxt = ST_SETUP;
         ST_SETUP:                                  state_nxt = ST_PULSE;
         ST_PULSE:                                  state_nxt = ST_HOLD;
         ST_HOLD:    state_nxt = last_word ? ST_DONE : ST_COLLECT;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   // Every output is a flop loaded from a decode of the next state. Each
   // output therefore changes on the same edge as the state, with no
   // combinational path from the state register to the pins.
   always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
      if (reset_of_clk10M) begin
         state         <= ST_IDLE;
         lane          <= '0;
         in_ready      <= 1'b0;
         ram_req       <= 1'b0;
         ram_ce_n      <= 1'b1;
         ram_we_n      <= 1'b1;
         ram_data_oe   <= 1'b0;
         ram_addr      <= BASE_ADDR;
         ram_wdata     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
         words_written <= '0;
      end else begin
         state       <= state_nxt;
         in_ready    <= (state_nxt == ST_COLLECT);
         ram_req     <= state_owns_bus(state_nxt);
         ram_ce_n    <= ~state_drives_sram(state_nxt);
         ram_data_oe <= state_drives_sram(state_nxt);
         ram_we_n    <= ~(state_nxt == ST_PULSE);
         busy        <= state_is_busy(state_nxt);

         if (start_ok) begin
            words_written <= '0;
            lane          <= '0;
            overrun       <= 1'b0;
            done          <= 1'b0;
         end

         if (accept) begin
            ram_wdata[{lane, 3'b000} +: 8] <= in_data;
            lane                           <= lane + 2'd1;
         end

         // Address is latched as the write cycle opens and held through HOLD
         if ((state == ST_REQ) && ram_gnt)
            ram_addr <= BASE_ADDR + words_written;

         if (state == ST_HOLD) begin
            words_written <= words_inc;
            if (last_word)
               done <= 1'b1;
         end

         if (state_is_busy(state) && in_valid && !in_ready)
            overrun <= 1'b1;
      end
   end

endmodule
